cache_refill_ctrl: RTL and testbench
====================================

CACHE_REFILL_CTRL -- requirements
Module: cache_refill_ctrl

Interface
REQ-001 Parameter: CACHELINE_WD, default 512, cache line width in bits; SHALL be a multiple of 32.
REQ-002 Parameter: BEATS, default CACHELINE_WD/32, 32-bit data beats per line.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 miss  input  1  cache lookup missed; held high until refresh is seen.
REQ-006 write_back  input  1  victim line is dirty; qualified by miss.
REQ-007 raddr  input  32  refill line address.
REQ-008 waddr  input  32  victim line address.
REQ-009 cacheline_old  input  CACHELINE_WD  victim line data.
REQ-010 refresh  output  1  one-cycle pulse: cacheline_new is valid; cache installs the line.
REQ-011 cacheline_new  output  CACHELINE_WD  assembled refill line.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 ar_valid/ar_ready/ar_addr  out/in/out  1/1/32  read-address handshake.
REQ-014 r_valid/r_data/r_last  in/in/in  1/32/1  read data beats; r_ready is implied as always 1.
REQ-015 aw_valid/aw_ready/aw_addr  out/in/out  1/1/32  write-address handshake.
REQ-016 w_valid/w_ready/w_data/w_last  out/in/out/out  1/1/32/1  write data beats.
REQ-017 b_valid  input  1  write response; b_ready is implied as always 1.

Function
REQ-018 States SHALL be IDLE, WB_AW, WB_W, WB_B, RD_AR, RD_R, REFILL, DONE.
REQ-019 IDLE and miss&write_back SHALL latch waddr, raddr and cacheline_old, then go to WB_AW; IDLE and miss&!write_back SHALL latch raddr, then go to RD_AR.
REQ-020 Latched addresses SHALL be line-aligned: bits [log2(CACHELINE_WD/8)-1:0] forced to 0 (bits [5:0] for 512).
REQ-021 WB_AW: aw_valid=1 with a stable address until aw_valid&aw_ready, then go to WB_W.
REQ-022 WB_W: w_data = cacheline_old latched word[beat]; beat 0 = bits [31:0]; beat advances on w_valid&w_ready; w_last=1 only on beat BEATS-1; the accepted last beat goes to WB_B.
REQ-023 WB_B: wait for b_valid, then go to RD_AR; write-back SHALL always complete before the refill read.
REQ-024 RD_AR: ar_valid=1 until ar_valid&ar_ready, then go to RD_R.
REQ-025 RD_R: each r_valid beat i SHALL be stored to cacheline_new bits [32*i+31:32*i]; the beat counter, not r_last, ends the burst; after beat BEATS-1 go to REFILL.
REQ-026 REFILL: refresh=1 for exactly one cycle, then go to DONE.
REQ-027 DONE: one cycle, miss ignored (cache deasserts miss), then go to IDLE.
REQ-028 Beat counter width: $clog2(BEATS); cleared on entry to WB_W and RD_R.
REQ-029 Latency from a clean-miss IDLE cycle to refresh, with zero-wait-state ready signals and contiguous r_valid: BEATS+3 cycles.
REQ-030 r_valid outside RD_R and b_valid outside WB_B SHALL be ignored.
REQ-031 cacheline_new SHALL hold its value outside RD_R.
REQ-032 Only ar_valid/aw_valid/w_valid and refresh are state-decoded; no combinational path from any input to these outputs except through state.

Reset
REQ-033 rst SHALL force IDLE, beat counter 0, and refresh/busy/ar_valid/aw_valid/w_valid/w_last = 0.
REQ-034 rst SHALL force ar_addr/aw_addr/w_data/cacheline_new = 0.
REQ-035 rst mid-burst SHALL abandon the transaction and take effect on the next edge; no refresh pulse SHALL follow.

Structure
REQ-036 A shared package SHALL hold the state enumeration, BEATS derivation, and line-offset width constant.
REQ-037 One sub-module, line_beat_buf, SHALL hold the CACHELINE_WD shift/index register used for both write-beat select and read-beat assembly; the FSM SHALL live in the top module.

Verification
REQ-038 Clean miss, raddr=0x1000_0044, ready always 1, r_data=i on beat i -> ar_addr=0x1000_0040, refresh at cycle 19, cacheline_new word i = i, busy low at cycle 21.
REQ-039 Dirty miss, waddr=0x2000_0000, cacheline_old word i = 0xA0+i -> 16 w beats 0xA0..0xAF, w_last only on beat 15, ar_valid only after b_valid, then refill.
REQ-040 aw_ready held low 5 cycles and w_ready toggling every other cycle -> aw_addr stable; each beat sent exactly once; no beat skipped or duplicated.
REQ-041 r_valid gaps (3 idle cycles after beat 7) -> line assembled correctly, refresh after beat 15 only.
REQ-042 rst asserted at RD_R beat 5 -> next cycle IDLE, all outputs 0, no refresh; a new miss afterwards completes normally.
REQ-043 miss held high through DONE -> exactly one transaction and one refresh pulse.

Source files
------------

// File: rtl/cache_refill_ctrl_pkg.sv
// Shared types and constants for the cache refill controller: FSM state
// encoding, beat-count derivation and line-offset width helpers.
package cache_refill_ctrl_pkg;

  // Bus word size; every line is moved as a burst of these.
  localparam int unsigned WORD_WD = 32;

  // Default line geometry (64-byte line).
  localparam int unsigned DEF_LINE_WD = 512;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WB_AW,
    ST_WB_W,
    ST_WB_B,
    ST_RD_AR,
    ST_RD_R,
    ST_REFILL,
    ST_DONE
  } state_e;

  // Number of bus beats needed to move one line.
  function automatic int unsigned beats_of(input int unsigned line_wd);
    return line_wd / WORD_WD;
  endfunction

  // Number of byte-offset address bits inside one line.
  function automatic int unsigned line_off_wd(input int unsigned line_wd);
    return $clog2(line_wd / 8);
  endfunction

  // Beat counter width; kept at least one bit for single-beat lines.
  function automatic int unsigned beat_cnt_wd(input int unsigned beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

  localparam int unsigned DEF_BEATS       = beats_of(DEF_LINE_WD);
  localparam int unsigned DEF_LINE_OFF_WD = line_off_wd(DEF_LINE_WD);

endpackage

// File: rtl/cache_refill_ctrl_line_beat_buf.sv
// Line buffer shared by both burst directions: holds the captured victim
// line (selected one word per write beat) and assembles the refill line
// one word per read beat.
module line_beat_buf
  import cache_refill_ctrl_pkg::*;
#(
  parameter int unsigned LINE_WD = DEF_LINE_WD,
  parameter int unsigned BEATS   = beats_of(LINE_WD),
  parameter int unsigned CNT_WD  = beat_cnt_wd(BEATS)
) (
  input  logic               clk,
  input  logic               srst,
  input  logic               load_i,
  input  logic [LINE_WD-1:0] victim_i,
  input  logic               wr_i,
  input  logic [CNT_WD-1:0]  idx_i,
  input  logic [WORD_WD-1:0] wr_word_i,
  output logic [WORD_WD-1:0] rd_word_o,
  output logic [LINE_WD-1:0] fill_o
);

  logic [LINE_WD-1:0] victim_flat;

  genvar gi;
  generate
    for (gi = 0; gi < BEATS; gi++) begin : g_word
      logic [WORD_WD-1:0] victim_q;
      logic [WORD_WD-1:0] fill_q;

      // Capture this word of the victim line, and this word of the refill line when its beat arrives
      always_ff @(posedge clk) begin
        if (srst) begin
          victim_q <= '0;
          fill_q   <= '0;
        end else begin
          if (load_i) begin
            victim_q <= victim_i[gi*WORD_WD +: WORD_WD];
          end
          if (wr_i && (idx_i == CNT_WD'(gi))) begin
            fill_q <= wr_word_i;
          end
        end
      end

      assign victim_flat[gi*WORD_WD +: WORD_WD] = victim_q;
      assign fill_o[gi*WORD_WD +: WORD_WD]      = fill_q;
    end
  endgenerate

  // Select the victim word for the current write beat
  always_comb begin
    rd_word_o = '0;
    for (int i = 0; i < BEATS; i++) begin
      if (idx_i == CNT_WD'(i)) begin
        rd_word_o = victim_flat[i*WORD_WD +: WORD_WD];
      end
    end
  end

endmodule

// File: rtl/cache_refill_ctrl.sv
// Cache miss refill controller: optionally writes back a dirty victim line
// as a burst, then reads the missing line as a burst, assembles it and
// pulses refresh so the cache can install it.
module cache_refill_ctrl
  import cache_refill_ctrl_pkg::*;
#(
  parameter int unsigned CACHELINE_WD = DEF_LINE_WD,
  parameter int unsigned BEATS        = beats_of(CACHELINE_WD)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    miss,
  input  logic                    write_back,
  input  logic [31:0]             raddr,
  input  logic [31:0]             waddr,
  input  logic [CACHELINE_WD-1:0] cacheline_old,
  output logic                    refresh,
  output logic [CACHELINE_WD-1:0] cacheline_new,
  output logic                    busy,
  output logic                    ar_valid,
  input  logic                    ar_ready,
  output logic [31:0]             ar_addr,
  input  logic                    r_valid,
  input  logic [31:0]             r_data,
  input  logic                    r_last,
  output logic                    aw_valid,
  input  logic                    aw_ready,
  output logic [31:0]             aw_addr,
  output logic                    w_valid,
  input  logic                    w_ready,
  output logic [31:0]             w_data,
  output logic                    w_last,
  input  logic                    b_valid
);

  localparam int unsigned       CNT_WD     = beat_cnt_wd(BEATS);
  localparam int unsigned       OFF_WD     = line_off_wd(CACHELINE_WD);
  localparam logic [CNT_WD-1:0] LAST_BEAT  = CNT_WD'(BEATS - 1);
  localparam logic [31:0]       ALIGN_MASK = ~((32'd1 << OFF_WD) - 32'd1);

  state_e            state_q;
  logic [CNT_WD-1:0] beat_q;
  logic [31:0]       ar_addr_q;
  logic [31:0]       aw_addr_q;
  logic [31:0]       ar_addr_d;
  logic [31:0]       aw_addr_d;
  logic              victim_load;
  logic              fill_wr;

  // The burst length is fixed by the beat counter, so r_last carries no extra information.
  logic unused_r_last;
  assign unused_r_last = r_last;

  assign ar_addr_d   = raddr & ALIGN_MASK;
  assign aw_addr_d   = waddr & ALIGN_MASK;
  assign victim_load = (state_q == ST_IDLE) && miss && write_back;
  assign fill_wr     = (state_q == ST_RD_R) && r_valid;

  // Control FSM: state, shared beat counter and latched line-aligned addresses
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      beat_q    <= '0;
      ar_addr_q <= '0;
      aw_addr_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (miss) begin
            ar_addr_q <= ar_addr_d;
            if (write_back) begin
              aw_addr_q <= aw_addr_d;
              state_q   <= ST_WB_AW;
            end else begin
              state_q <= ST_RD_AR;
            end
          end
        end
        ST_WB_AW: begin
          if (aw_ready) begin
            beat_q  <= '0;
            state_q <= ST_WB_W;
          end
        end
        ST_WB_W: begin
          if (w_ready) begin
            if (beat_q == LAST_BEAT) begin
              state_q <= ST_WB_B;
            end else begin
              beat_q <= beat_q + CNT_WD'(1);
            end
          end
        end
        ST_WB_B: begin
          if (b_valid) begin
            state_q <= ST_RD_AR;
          end
        end
        ST_RD_AR: begin
          if (ar_ready) begin
            beat_q  <= '0;
            state_q <= ST_RD_R;
          end
        end
        ST_RD_R: begin
          if (r_valid) begin
            if (beat_q == LAST_BEAT) begin
              state_q <= ST_REFILL;
            end else begin
              beat_q <= beat_q + CNT_WD'(1);
            end
          end
        end
        ST_REFILL: state_q <= ST_DONE;
        ST_DONE:   state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  line_beat_buf #(
    .LINE_WD (CACHELINE_WD),
    .BEATS   (BEATS),
    .CNT_WD  (CNT_WD)
  ) u_buf (
    .clk       (clk),
    .srst      (rst),
    .load_i    (victim_load),
    .victim_i  (cacheline_old),
    .wr_i      (fill_wr),
    .idx_i     (beat_q),
    .wr_word_i (r_data),
    .rd_word_o (w_data),
    .fill_o    (cacheline_new)
  );

  // Handshake valids and the refresh pulse depend only on registered state.
  assign aw_valid = (state_q == ST_WB_AW);
  assign w_valid  = (state_q == ST_WB_W);
  assign w_last   = (state_q == ST_WB_W) && (beat_q == LAST_BEAT);
  assign ar_valid = (state_q == ST_RD_AR);
  assign refresh  = (state_q == ST_REFILL);
  assign busy     = (state_q != ST_IDLE);
  assign ar_addr  = ar_addr_q;
  assign aw_addr  = aw_addr_q;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Bench for cache_refill_ctrl: a bus responder process, a scoreboard
// monitor for write beats and refreshed lines, and one task per scenario.
module tb_cache_refill_ctrl;

  localparam int LINE_WD = 512;
  localparam int BEATS   = 16;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               miss = 1'b0;
  logic               write_back = 1'b0;
  logic [31:0]        raddr = '0;
  logic [31:0]        waddr = '0;
  logic [LINE_WD-1:0] cacheline_old = '0;
  logic               refresh;
  logic [LINE_WD-1:0] cacheline_new;
  logic               busy;
  logic               ar_valid;
  logic               ar_ready;
  logic [31:0]        ar_addr;
  logic               r_valid;
  logic [31:0]        r_data;
  logic               r_last;
  logic               aw_valid;
  logic               aw_ready;
  logic [31:0]        aw_addr;
  logic               w_valid;
  logic               w_ready;
  logic [31:0]        w_data;
  logic               w_last;
  logic               b_valid;

  cache_refill_ctrl #(.CACHELINE_WD(LINE_WD)) dut (
    .clk           (clk),
    .rst           (rst),
    .miss          (miss),
    .write_back    (write_back),
    .raddr         (raddr),
    .waddr         (waddr),
    .cacheline_old (cacheline_old),
    .refresh       (refresh),
    .cacheline_new (cacheline_new),
    .busy          (busy),
    .ar_valid      (ar_valid),
    .ar_ready      (ar_ready),
    .ar_addr       (ar_addr),
    .r_valid       (r_valid),
    .r_data        (r_data),
    .r_last        (r_last),
    .aw_valid      (aw_valid),
    .aw_ready      (aw_ready),
    .aw_addr       (aw_addr),
    .w_valid       (w_valid),
    .w_ready       (w_ready),
    .w_data        (w_data),
    .w_last        (w_last),
    .b_valid       (b_valid)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int c_start = 0;

  // responder configuration
  int          aw_stall_cfg = 0;
  bit          w_toggle_cfg = 0;
  int          r_gap_after = -1;
  int          r_gap_len = 0;
  bit          r_last_early = 0;
  int          b_delay_cfg = 0;
  logic [31:0] rd_base = '0;

  // responder state and timestamps
  bit rd_pending = 0;
  int rd_beat = 0;
  int gap_cnt = 0;
  bit b_pend = 0;
  int b_cnt = 0;
  int aw_wait = 0;
  int b_cycle = -1;
  int ar_first_cycle = -1;

  // scoreboard
  logic [31:0]        exp_w_data_q[$];
  logic               exp_w_last_q[$];
  logic [LINE_WD-1:0] exp_line_q[$];
  int                 w_beats_seen = 0;
  int                 refresh_count = 0;
  logic [31:0]        sb_data;
  logic               sb_last;
  logic [LINE_WD-1:0] sb_line;

  // per-transaction observations
  bit          obs_aw_seen, obs_aw_unstable, obs_ar_seen;
  logic [31:0] obs_aw_addr, obs_ar_addr;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Bus responder: samples handshakes mid-cycle, drives after the edge.
  initial begin
    bit s_rst, s_ar, s_r, s_aw_v, s_aw, s_wlast;
    ar_ready = 1'b1; aw_ready = 1'b1; w_ready = 1'b1;
    r_valid = 1'b0; r_data = '0; r_last = 1'b0; b_valid = 1'b0;
    forever begin
      @(negedge clk);
      s_rst   = rst;
      s_ar    = ar_valid && ar_ready;
      s_r     = r_valid;
      s_aw_v  = aw_valid;
      s_aw    = aw_valid && aw_ready;
      s_wlast = w_valid && w_ready && w_last;
      if (b_valid) b_cycle = cyc;
      if (ar_valid && ar_first_cycle < 0) ar_first_cycle = cyc;
      @(posedge clk);
      #1;
      if (s_rst) begin
        rd_pending = 0; rd_beat = 0; gap_cnt = 0; b_pend = 0; aw_wait = 0;
        r_valid = 1'b0; r_last = 1'b0; b_valid = 1'b0; w_ready = 1'b1;
        aw_ready = (aw_stall_cfg == 0);
      end else begin
        if (s_ar) begin
          rd_pending = 1; rd_beat = 0; gap_cnt = 0;
        end else if (s_r && rd_pending) begin
          if (rd_beat == r_gap_after) gap_cnt = r_gap_len;
          rd_beat++;
        end
        if (rd_pending) begin
          if (rd_beat >= BEATS) begin
            rd_pending = 0; r_valid = 1'b0; r_last = 1'b0;
          end else if (gap_cnt > 0) begin
            r_valid = 1'b0; r_last = 1'b0; gap_cnt--;
          end else begin
            r_valid = 1'b1;
            r_data  = rd_base + 32'(rd_beat);
            r_last  = (rd_beat == BEATS - 1) || (r_last_early && rd_beat == r_gap_after);
          end
        end
        if (s_aw) aw_wait = 0;
        else if (s_aw_v) aw_wait++;
        aw_ready = (aw_wait >= aw_stall_cfg);
        w_ready = w_toggle_cfg ? ~w_ready : 1'b1;
        if (s_wlast) begin
          b_pend = 1; b_cnt = b_delay_cfg;
        end
        if (b_valid) b_valid = 1'b0;
        else if (b_pend) begin
          if (b_cnt == 0) begin
            b_valid = 1'b1; b_pend = 0;
          end else b_cnt--;
        end
      end
    end
  end

  // Scoreboard monitor: every accepted write beat and every refresh pops an expectation.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (w_valid && w_ready) begin
        w_beats_seen++;
        checks++;
        if (exp_w_data_q.size() == 0) begin
          $display("FAIL w_beat_unexpected: got data=%h last=%b, required no beat", w_data, w_last);
        end else begin
          sb_data = exp_w_data_q.pop_front();
          sb_last = exp_w_last_q.pop_front();
          if (w_data !== sb_data || w_last !== sb_last)
            $display("FAIL w_beat: got data=%h last=%b, required data=%h last=%b", w_data, w_last, sb_data, sb_last);
          else passes++;
        end
        $display("w beat data=%h last=%b", w_data, w_last);
      end
      if (refresh) begin
        refresh_count++;
        checks++;
        if (exp_line_q.size() == 0) begin
          $display("FAIL refresh_unexpected: got refresh with line=%h", cacheline_new);
        end else begin
          sb_line = exp_line_q.pop_front();
          if (cacheline_new !== sb_line)
            $display("FAIL refresh_line: got %h required %h", cacheline_new, sb_line);
          else passes++;
        end
        $display("refresh at cycle %0d", cyc);
      end
    end
  end

  function automatic logic [LINE_WD-1:0] mk_line(input logic [31:0] base);
    logic [LINE_WD-1:0] l;
    for (int i = 0; i < BEATS; i++) l[i*32 +: 32] = base + 32'(i);
    return l;
  endfunction

  task automatic set_defaults();
    aw_stall_cfg = 0; w_toggle_cfg = 0; r_gap_after = -1; r_gap_len = 0;
    r_last_early = 0; b_delay_cfg = 0; rd_base = '0;
  endtask

  task automatic push_wb(input logic [LINE_WD-1:0] old);
    for (int i = 0; i < BEATS; i++) begin
      exp_w_data_q.push_back(old[i*32 +: 32]);
      exp_w_last_q.push_back(i == BEATS - 1);
    end
  endtask

  task automatic start_miss(input bit wb, input logic [31:0] ra, input logic [31:0] wa,
                            input logic [LINE_WD-1:0] old);
    @(posedge clk);
    #1;
    miss = 1'b1; write_back = wb; raddr = ra; waddr = wa; cacheline_old = old;
    c_start = cyc; b_cycle = -1; ar_first_cycle = -1;
  endtask

  // Observe a transaction until the controller returns to idle; cycle 1 is the miss cycle.
  task automatic run_txn(input int budget, input bit hold_done, output int ref_rel, output int idle_rel);
    ref_rel = -1; idle_rel = -1;
    obs_aw_seen = 0; obs_aw_unstable = 0; obs_ar_seen = 0;
    obs_aw_addr = '0; obs_ar_addr = '0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (aw_valid) begin
        if (!obs_aw_seen) begin
          obs_aw_seen = 1; obs_aw_addr = aw_addr;
        end else if (aw_addr !== obs_aw_addr) obs_aw_unstable = 1;
      end
      if (ar_valid && !obs_ar_seen) begin
        obs_ar_seen = 1; obs_ar_addr = ar_addr;
      end
      if (ref_rel >= 0 && !busy) begin
        idle_rel = cyc - c_start + 1;
        break;
      end
      if (refresh && ref_rel < 0) begin
        ref_rel = cyc - c_start + 1;
        @(posedge clk);
        #1;
        if (hold_done) begin
          @(posedge clk);
          #1;
        end
        miss = 1'b0; write_back = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, refresh, ar_valid, aw_valid, w_valid, w_last} !== 6'b0)
      $display("FAIL reset_ctrl: got %b required 000000", {busy, refresh, ar_valid, aw_valid, w_valid, w_last});
    else passes++;
    checks++;
    if ({ar_addr, aw_addr, w_data} !== 96'b0)
      $display("FAIL reset_addr: got ar=%h aw=%h wd=%h required 0", ar_addr, aw_addr, w_data);
    else passes++;
    checks++;
    if (cacheline_new !== '0) $display("FAIL reset_line: got %h required 0", cacheline_new);
    else passes++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) $display("FAIL reset_release_busy: got %b required 0", busy);
    else passes++;
    $display("test_reset done");
  endtask

  task automatic test_clean_latency();
    int ref_rel, idle_rel;
    set_defaults();
    exp_line_q.push_back(mk_line(32'h0));
    start_miss(1'b0, 32'h1000_0044, 32'h0, '0);
    run_txn(60, 1'b0, ref_rel, idle_rel);
    checks++;
    if (ref_rel != 19) $display("FAIL clean_refresh_cycle: got %0d required 19", ref_rel);
    else passes++;
    checks++;
    if (idle_rel != 21) $display("FAIL clean_idle_cycle: got %0d required 21", idle_rel);
    else passes++;
    checks++;
    if (!obs_ar_seen || obs_ar_addr !== 32'h1000_0040)
      $display("FAIL clean_ar_addr: got seen=%0d addr=%h required 10000040", obs_ar_seen, obs_ar_addr);
    else passes++;
    checks++;
    if (cacheline_new !== mk_line(32'h0)) $display("FAIL clean_line_hold: got %h required %h", cacheline_new, mk_line(32'h0));
    else passes++;
    $display("test_clean_latency refresh=%0d idle=%0d", ref_rel, idle_rel);
  endtask

  task automatic test_dirty();
    int ref_rel, idle_rel, w0;
    logic [LINE_WD-1:0] old;
    set_defaults();
    b_delay_cfg = 2;
    rd_base = 32'h5000;
    for (int i = 0; i < BEATS; i++) old[i*32 +: 32] = 32'hA0 + 32'(i);
    push_wb(old);
    exp_line_q.push_back(mk_line(32'h5000));
    w0 = w_beats_seen;
    start_miss(1'b1, 32'h3000_00BC, 32'h2000_0000, old);
    run_txn(120, 1'b0, ref_rel, idle_rel);
    checks++;
    if (w_beats_seen - w0 != 16 || exp_w_data_q.size() != 0)
      $display("FAIL dirty_beat_count: got %0d left=%0d required 16 left=0", w_beats_seen - w0, exp_w_data_q.size());
    else passes++;
    checks++;
    if (obs_aw_addr !== 32'h2000_0000) $display("FAIL dirty_aw_addr: got %h required 20000000", obs_aw_addr);
    else passes++;
    checks++;
    if (b_cycle < 0 || ar_first_cycle != b_cycle + 1)
      $display("FAIL dirty_ar_after_b: got ar=%0d b=%0d required ar=b+1", ar_first_cycle, b_cycle);
    else passes++;
    checks++;
    if (obs_ar_addr !== 32'h3000_0080) $display("FAIL dirty_ar_addr: got %h required 30000080", obs_ar_addr);
    else passes++;
    checks++;
    if (ref_rel != 39) $display("FAIL dirty_refresh_cycle: got %0d required 39", ref_rel);
    else passes++;
    $display("test_dirty refresh=%0d b=%0d ar=%0d", ref_rel, b_cycle, ar_first_cycle);
  endtask

  task automatic test_stall();
    int ref_rel, idle_rel, w0;
    logic [LINE_WD-1:0] old;
    set_defaults();
    aw_stall_cfg = 5;
    w_toggle_cfg = 1;
    rd_base = 32'h0BAD_0000;
    for (int i = 0; i < BEATS; i++) old[i*32 +: 32] = $urandom();
    push_wb(old);
    exp_line_q.push_back(mk_line(32'h0BAD_0000));
    w0 = w_beats_seen;
    start_miss(1'b1, 32'h1000_0000, 32'h2000_1234, old);
    run_txn(200, 1'b0, ref_rel, idle_rel);
    checks++;
    if (obs_aw_unstable || obs_aw_addr !== 32'h2000_1200)
      $display("FAIL stall_aw_addr: got %h unstable=%0d required 20001200 stable", obs_aw_addr, obs_aw_unstable);
    else passes++;
    checks++;
    if (w_beats_seen - w0 != 16 || exp_w_data_q.size() != 0)
      $display("FAIL stall_beat_count: got %0d left=%0d required 16 left=0", w_beats_seen - w0, exp_w_data_q.size());
    else passes++;
    checks++;
    if (ref_rel < 0 || idle_rel < 0) $display("FAIL stall_complete: got refresh=%0d idle=%0d required both seen", ref_rel, idle_rel);
    else passes++;
    $display("test_stall refresh=%0d", ref_rel);
  endtask

  task automatic test_gap();
    int ref_rel, idle_rel, rc;
    set_defaults();
    r_gap_after = 7;
    r_gap_len = 3;
    r_last_early = 1;
    rd_base = 32'h7700;
    exp_line_q.push_back(mk_line(32'h7700));
    rc = refresh_count;
    start_miss(1'b0, 32'h4000_0010, 32'h0, '0);
    run_txn(80, 1'b0, ref_rel, idle_rel);
    checks++;
    if (ref_rel != 22) $display("FAIL gap_refresh_cycle: got %0d required 22", ref_rel);
    else passes++;
    checks++;
    if (refresh_count - rc != 1) $display("FAIL gap_refresh_count: got %0d required 1", refresh_count - rc);
    else passes++;
    checks++;
    if (obs_ar_addr !== 32'h4000_0000) $display("FAIL gap_ar_addr: got %h required 40000000", obs_ar_addr);
    else passes++;
    $display("test_gap refresh=%0d", ref_rel);
  endtask

  task automatic test_reset_mid();
    int ref_rel, idle_rel, rc;
    bit found;
    set_defaults();
    rd_base = 32'h9900;
    found = 0;
    start_miss(1'b0, 32'h5000_0004, 32'h0, '0);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (r_valid && rd_beat == 5) begin
        found = 1;
        break;
      end
    end
    checks++;
    if (!found) $display("FAIL midrst_reach_beat5: got no beat 5 required beat 5");
    else passes++;
    rst = 1'b1;
    @(posedge clk);
    #1;
    miss = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, refresh, ar_valid, aw_valid, w_valid, w_last} !== 6'b0)
      $display("FAIL midrst_ctrl: got %b required 000000", {busy, refresh, ar_valid, aw_valid, w_valid, w_last});
    else passes++;
    checks++;
    if ({ar_addr, aw_addr, w_data} !== 96'b0 || cacheline_new !== '0)
      $display("FAIL midrst_data: got ar=%h aw=%h wd=%h line_nonzero=%0d required 0", ar_addr, aw_addr, w_data, |cacheline_new);
    else passes++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    rc = refresh_count;
    repeat (20) @(negedge clk);
    checks++;
    if (refresh_count != rc || busy !== 1'b0)
      $display("FAIL midrst_no_refresh: got refreshes=%0d busy=%b required 0 and 0", refresh_count - rc, busy);
    else passes++;
    exp_line_q.push_back(mk_line(32'h9900));
    start_miss(1'b0, 32'h5000_0004, 32'h0, '0);
    run_txn(60, 1'b0, ref_rel, idle_rel);
    checks++;
    if (ref_rel != 19) $display("FAIL midrst_recover: got %0d required 19", ref_rel);
    else passes++;
    $display("test_reset_mid recover refresh=%0d", ref_rel);
  endtask

  task automatic test_miss_hold();
    int ref_rel, idle_rel, rc;
    bit busy_again;
    set_defaults();
    rd_base = 32'h00C0_0000;
    exp_line_q.push_back(mk_line(32'h00C0_0000));
    rc = refresh_count;
    busy_again = 0;
    start_miss(1'b0, 32'h6000_0000, 32'h0, '0);
    run_txn(60, 1'b1, ref_rel, idle_rel);
    repeat (30) begin
      @(negedge clk);
      if (busy) busy_again = 1;
    end
    checks++;
    if (idle_rel != 21) $display("FAIL hold_idle_cycle: got %0d required 21", idle_rel);
    else passes++;
    checks++;
    if (refresh_count - rc != 1 || busy_again)
      $display("FAIL hold_single_txn: got refreshes=%0d rebusy=%0d required 1 and 0", refresh_count - rc, busy_again);
    else passes++;
    $display("test_miss_hold refresh=%0d idle=%0d", ref_rel, idle_rel);
  endtask

  initial begin
    test_reset();
    test_clean_latency();
    test_dirty();
    test_stall();
    test_gap();
    test_reset_mid();
    test_miss_hold();
    checks++;
    if (exp_line_q.size() != 0 || exp_w_data_q.size() != 0)
      $display("FAIL scoreboard_drain: got lines=%0d beats=%0d left required 0", exp_line_q.size(), exp_w_data_q.size());
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
